register_stack: RTL and testbench

Eight-entry, 32-bit LIFO register stack that holds operands pushed from the board switches/buttons and presents a selected entry as the 32-bit word for the four-digit seven-segment display stage. It also generates that display stage's scan clock (CLK_S) and registers its half-word select (Sel), so it drives every input of the display stage directly. All logic runs on CLK.

---
 rtl/register_stack.sv | 131 +++++++++++++
 tb/tb_register_stack.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/register_stack.sv
// Eight-entry LIFO operand stack feeding the seven-segment display stage.
// Also produces the display's scan clock and registered half-word select.
module register_stack #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         Push,
    input  logic                         Pop,
    input  logic [WIDTH-1:0]             Din,
    input  logic [$clog2(DEPTH)-1:0]     Peek,
    input  logic                         Sel_In,
    output logic [WIDTH-1:0]             Data,
    output logic                         Sel,
    output logic                         CLK_S,
    output logic [$clog2(DEPTH+1)-1:0]   Count,
    output logic                         Full,
    output logic                         Empty,
    output logic                         Err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    sp_q, sp_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] data_q, rd_data;
    logic             sel_q;
    logic [DW-1:0]    div_q, div_d;
    logic             clk_s_q, clk_s_d;

    logic             full, empty;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [CW-1:0]    peek_ext;

    assign full     = (sp_q == CW'(DEPTH));
    assign empty    = (sp_q == '0);
    assign peek_ext = CW'(Peek);

    // Stack pointer, error flag and write-port decode.
    always_comb begin
        sp_d    = sp_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        wr_addr = '0;
        unique case ({Push, Pop})
            2'b10: begin
                if (!full) begin
                    wr_en   = 1'b1;
                    wr_addr = AW'(sp_q);
                    sp_d    = sp_q + CW'(1);
                end else begin
                    err_d = 1'b1;
                end
            end
            2'b01: begin
                if (!empty) begin
                    sp_d = sp_q - CW'(1);
                end else begin
                    err_d = 1'b1;
                end
            end
            2'b11: begin
                // Replace top; on an empty stack this degenerates to a push.
                wr_en = 1'b1;
                if (empty) begin
                    wr_addr = '0;
                    sp_d    = CW'(1);
                end else begin
                    wr_addr = AW'(sp_q - CW'(1));
                end
            end
            default: ;
        endcase
    end

    // Entries at or above sp are stale and must read as zero.
    always_comb begin
        rd_data = '0;
        if (peek_ext < sp_q) begin
            rd_data = mem_q[AW'(sp_q - CW'(1) - peek_ext)];
        end
    end

    always_comb begin
        div_d   = div_q + DW'(1);
        clk_s_d = clk_s_q;
        if (div_q == DW'(SCAN_DIV - 1)) begin
            div_d   = '0;
            clk_s_d = ~clk_s_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sp_q    <= '0;
            err_q   <= 1'b0;
            data_q  <= '0;
            sel_q   <= 1'b0;
            div_q   <= '0;
            clk_s_q <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            err_q   <= err_d;
            data_q  <= rd_data;
            sel_q   <= Sel_In;
            div_q   <= div_d;
            clk_s_q <= clk_s_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && wr_en) begin
            mem_q[wr_addr] <= Din;
        end
    end

    assign Data  = data_q;
    assign Sel   = sel_q;
    assign CLK_S = clk_s_q;
    assign Count = sp_q;
    assign Full  = full;
    assign Empty = empty;
    assign Err   = err_q;

endmodule

// File: tb/tb_register_stack.sv
// Self-checking bench for register_stack: directed scenarios plus randomized
// traffic compared against a queue-based stack model.
module tb_register_stack;

    localparam int unsigned SCAN_DIV = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        Push = 1'b0;
    logic        Pop = 1'b0;
    logic [31:0] Din = '0;
    logic [2:0]  Peek = '0;
    logic        Sel_In = 1'b0;
    logic [31:0] Data;
    logic        Sel;
    logic        CLK_S;
    logic [3:0]  Count;
    logic        Full;
    logic        Empty;
    logic        Err;

    int checks = 0;
    int errors = 0;

    // Reference model
    logic [31:0] stk[$];
    bit          m_err;
    logic [31:0] m_data;
    bit          m_sel;
    int          n_edges;

    register_stack #(
        .DEPTH   (8),
        .WIDTH   (32),
        .SCAN_DIV(SCAN_DIV)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .Push  (Push),
        .Pop   (Pop),
        .Din   (Din),
        .Peek  (Peek),
        .Sel_In(Sel_In),
        .Data  (Data),
        .Sel   (Sel),
        .CLK_S (CLK_S),
        .Count (Count),
        .Full  (Full),
        .Empty (Empty),
        .Err   (Err)
    );

    always #5 CLK = ~CLK;

    task automatic model_edge(input bit rst, input bit push, input bit pop,
                              input logic [31:0] din, input int peek, input bit sel_in);
        if (rst) begin
            stk.delete();
            m_err   = 0;
            m_data  = '0;
            m_sel   = 0;
            n_edges = 0;
        end else begin
            m_data = (peek < stk.size()) ? stk[stk.size() - 1 - peek] : 32'h0;
            m_sel  = sel_in;
            n_edges++;
            if (push && !pop) begin
                if (stk.size() < 8) stk.push_back(din);
                else m_err = 1;
            end else if (pop && !push) begin
                if (stk.size() > 0) void'(stk.pop_back());
                else m_err = 1;
            end else if (push && pop) begin
                if (stk.size() > 0) stk[stk.size() - 1] = din;
                else stk.push_back(din);
            end
        end
    endtask

    // Drive one cycle of inputs, clock it, update model, settle.
    task automatic cyc(input bit rst, input bit push, input bit pop,
                       input logic [31:0] din, input logic [2:0] peek, input bit sel_in);
        RST = rst; Push = push; Pop = pop; Din = din; Peek = peek; Sel_In = sel_in;
        @(posedge CLK);
        model_edge(rst, push, pop, din, int'(peek), sel_in);
        #1;
        RST = 0; Push = 0; Pop = 0;
    endtask

    task automatic test_reset;
        cyc(1, 0, 0, 32'h0, 3'd0, 0);
        checks++; if (Data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", Data); end
        checks++; if (Count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", Count); end
        checks++; if (Empty !== 1'b1 || Full !== 1'b0) begin errors++; $display("FAIL reset_flags got E%b F%b exp E1 F0", Empty, Full); end
        checks++; if (Err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", Err); end
        checks++; if (CLK_S !== 1'b0 || Sel !== 1'b0) begin errors++; $display("FAIL reset_clks_sel got %b %b exp 0 0", CLK_S, Sel); end
        cyc(0, 0, 0, 32'h0, 3'd0, 0);
        checks++; if (Data !== 32'h0) begin errors++; $display("FAIL reset_peek0 got %h exp 0", Data); end
    endtask

    task automatic test_push_peek;
        cyc(1, 0, 0, 32'h0, 3'd0, 0);
        cyc(0, 1, 0, 32'h11111111, 3'd0, 0);
        cyc(0, 1, 0, 32'h22222222, 3'd0, 0);
        cyc(0, 1, 0, 32'h33333333, 3'd0, 0);
        checks++; if (Count !== 4'd3) begin errors++; $display("FAIL push_count got %0d exp 3", Count); end
        checks++; if (Data !== 32'h22222222) begin errors++; $display("FAIL push_data_lat got %h exp 22222222", Data); end
        cyc(0, 0, 0, 32'h0, 3'd0, 0);
        checks++; if (Data !== 32'h33333333) begin errors++; $display("FAIL peek0 got %h exp 33333333", Data); end
        cyc(0, 0, 0, 32'h0, 3'd2, 0);
        checks++; if (Data !== 32'h11111111) begin errors++; $display("FAIL peek2 got %h exp 11111111", Data); end
        cyc(0, 0, 0, 32'h0, 3'd3, 0);
        checks++; if (Data !== 32'h0) begin errors++; $display("FAIL peek3 got %h exp 0", Data); end
    endtask

    task automatic test_overflow;
        cyc(1, 0, 0, 32'h0, 3'd0, 0);
        for (int i = 1; i <= 9; i++) begin
            cyc(0, 1, 0, 32'hC000_0000 + i, 3'd0, 0);
            if (i == 7) begin
                checks++; if (Full !== 1'b0) begin errors++; $display("FAIL full_early got %b exp 0", Full); end
            end
            if (i == 8) begin
                checks++; if (Full !== 1'b1 || Err !== 1'b0) begin errors++; $display("FAIL full8 got F%b E%b exp F1 E0", Full, Err); end
            end
        end
        checks++; if (Err !== 1'b1 || Count !== 4'd8) begin errors++; $display("FAIL overflow got Err%b Cnt%0d exp Err1 Cnt8", Err, Count); end
        cyc(0, 0, 0, 32'h0, 3'd0, 0);
        checks++; if (Data !== 32'hC000_0008) begin errors++; $display("FAIL overflow_top got %h exp c0000008", Data); end
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, 32'h0, 3'd0, 0);
        checks++; if (Empty !== 1'b1 || Count !== 4'd0) begin errors++; $display("FAIL pop_all got E%b Cnt%0d exp E1 Cnt0", Empty, Count); end
        cyc(0, 0, 1, 32'h0, 3'd0, 0);
        checks++; if (Count !== 4'd0 || Err !== 1'b1 || Full !== 1'b0) begin errors++; $display("FAIL underflow got Cnt%0d Err%b F%b exp Cnt0 Err1 F0", Count, Err, Full); end
        cyc(0, 0, 0, 32'h0, 3'd0, 0);
        checks++; if (Err !== 1'b1 || Data !== 32'h0) begin errors++; $display("FAIL err_sticky got Err%b Data%h exp Err1 Data0", Err, Data); end
        cyc(1, 0, 0, 32'h0, 3'd0, 0);
        checks++; if (Err !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", Err); end
    endtask

    task automatic test_replace;
        cyc(1, 0, 0, 32'h0, 3'd0, 0);
        cyc(0, 1, 1, 32'hA5A5A5A5, 3'd0, 0);
        checks++; if (Count !== 4'd1 || Err !== 1'b0) begin errors++; $display("FAIL repl_empty got Cnt%0d Err%b exp Cnt1 Err0", Count, Err); end
        cyc(0, 0, 0, 32'h0, 3'd0, 0);
        checks++; if (Data !== 32'hA5A5A5A5) begin errors++; $display("FAIL repl_top1 got %h exp a5a5a5a5", Data); end
        cyc(0, 1, 1, 32'h5A5A5A5A, 3'd0, 0);
        cyc(0, 0, 0, 32'h0, 3'd0, 0);
        checks++; if (Count !== 4'd1 || Err !== 1'b0) begin errors++; $display("FAIL repl_count got Cnt%0d Err%b exp Cnt1 Err0", Count, Err); end
        checks++; if (Data !== 32'h5A5A5A5A) begin errors++; $display("FAIL repl_top2 got %h exp 5a5a5a5a", Data); end
    endtask

    task automatic test_scan_sel;
        int toggles;
        logic prev;
        cyc(1, 0, 0, 32'h0, 3'd0, 0);
        toggles = 0;
        prev = CLK_S;
        for (int n = 1; n <= 24; n++) begin
            bit s;
            s = n[1];
            cyc(0, 0, 0, 32'h0, 3'd0, s);
            checks++; if (CLK_S !== 1'(((n / SCAN_DIV) % 2))) begin errors++; $display("FAIL clks_edge%0d got %b exp %b", n, CLK_S, 1'((n / SCAN_DIV) % 2)); end
            checks++; if (Sel !== s) begin errors++; $display("FAIL sel_edge%0d got %b exp %b", n, Sel, s); end
            if (CLK_S !== prev) toggles++;
            prev = CLK_S;
        end
        checks++; if (toggles !== 6) begin errors++; $display("FAIL clks_toggles got %0d exp 6", toggles); end
    endtask

    task automatic test_reset_mid;
        cyc(1, 0, 0, 32'h0, 3'd0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 32'hD000_0000 + i, 3'd0, 0);
        cyc(0, 0, 1, 32'h0, 3'd0, 0);
        cyc(0, 1, 0, 32'hD000_0004, 3'd0, 0);
        checks++; if (Count !== 4'd5) begin errors++; $display("FAIL mid_pre got %0d exp 5", Count); end
        cyc(1, 1, 0, 32'hEEEEEEEE, 3'd0, 0);
        checks++; if (Count !== 4'd0 || Data !== 32'h0 || Err !== 1'b0 || CLK_S !== 1'b0) begin
            errors++; $display("FAIL mid_reset got Cnt%0d Data%h Err%b CLKS%b exp 0 0 0 0", Count, Data, Err, CLK_S);
        end
        cyc(0, 1, 0, 32'h12345678, 3'd0, 0);
        cyc(0, 0, 0, 32'h0, 3'd0, 0);
        checks++; if (Count !== 4'd1 || Data !== 32'h12345678) begin errors++; $display("FAIL mid_after got Cnt%0d Data%h exp 1 12345678", Count, Data); end
        cyc(0, 0, 0, 32'h0, 3'd1, 0);
        checks++; if (Data !== 32'h0) begin errors++; $display("FAIL mid_stale got %h exp 0", Data); end
    endtask

    task automatic test_random;
        cyc(1, 0, 0, 32'h0, 3'd0, 0);
        for (int n = 0; n < 400; n++) begin
            bit rst, push, pop, s;
            int r;
            r    = $urandom_range(0, 99);
            rst  = ($urandom_range(0, 79) == 0);
            push = (r < 45) || (r >= 85);
            pop  = (r >= 40);
            s    = 1'($urandom);
            cyc(rst, push, pop, $urandom, 3'($urandom), s);
            checks++; if (Data !== m_data) begin errors++; $display("FAIL rnd_data%0d got %h exp %h", n, Data, m_data); end
            checks++; if (Count !== 4'(stk.size())) begin errors++; $display("FAIL rnd_count%0d got %0d exp %0d", n, Count, stk.size()); end
            checks++; if (Full !== (stk.size() == 8) || Empty !== (stk.size() == 0)) begin
                errors++; $display("FAIL rnd_flags%0d got F%b E%b exp size %0d", n, Full, Empty, stk.size());
            end
            checks++; if (Err !== m_err) begin errors++; $display("FAIL rnd_err%0d got %b exp %b", n, Err, m_err); end
            checks++; if (Sel !== m_sel) begin errors++; $display("FAIL rnd_sel%0d got %b exp %b", n, Sel, m_sel); end
            checks++; if (CLK_S !== 1'((n_edges / SCAN_DIV) % 2)) begin
                errors++; $display("FAIL rnd_clks%0d got %b exp %b", n, CLK_S, 1'((n_edges / SCAN_DIV) % 2));
            end
        end
    endtask

    initial begin
        @(posedge CLK);
        #1;
        test_reset();
        test_push_peek();
        test_overflow();
        test_replace();
        test_scan_sel();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
